// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding and counter-width helper for serial_adder
package serial_adder_pkg;
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: one-bit full adder composed of two half-adder stages
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p, g1, g2;
    assign p    = x ^ y;
    assign g1   = x & y;
    assign s    = p ^ cin;
    assign g2   = p & cin;
    assign cout = g1 | g2;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial unsigned adder with start/busy/done; SERIAL_ADDER_OVF_EN adds ovf
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = clog2(WIDTH);
    logic             state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] sum_sh;
    logic [WIDTH-1:0] sum_nxt;
    logic [CW-1:0]    cnt;
    logic             carry, fa_s, fa_cout, last;
    full_adder u_fa (
        .x   (a_sh[0]),
        .y   (b_sh[0]),
        .cin (carry),
        .s   (fa_s),
        .cout(fa_cout)
    );
    assign last    = (state == ST_SHIFT) && (cnt == CW'(WIDTH - 1));
    assign sum_nxt = {fa_s, sum_sh};
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end
    always_comb begin
        state_nxt = (state == ST_IDLE) ? (start ? ST_SHIFT : ST_IDLE)
                                       : (last ? ST_IDLE : ST_SHIFT);
    end
    always_comb begin
        busy = (state == ST_SHIFT);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            done <= last;
            if (state == ST_IDLE && start) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= 1'b0;
                cnt   <= '0;
            end else if (state == ST_SHIFT) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                sum_sh <= sum_nxt[WIDTH-1:1];
                carry  <= fa_cout;
                cnt    <= cnt + 1'b1;
                if (last) begin
                    sum  <= sum_nxt;
                    cout <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry still holds the carry into the MSB on the final edge
                    ovf  <= carry ^ fa_cout;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder (honours SERIAL_ADDER_OVF_EN)
module tb_serial_adder;
    localparam int W = 5;
    logic         clk = 1'b0;
    logic         rst, start, busy, done, cout;
    logic [W-1:0] a, b, sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif
    int           n_chk = 0;
    int           n_err = 0;
    logic [W+1:0] sb[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] r;
        logic       v;
        r = {1'b0, x} + {1'b0, y};
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        sb.push_back({v, r});
    endtask

    task automatic wait_done(input string tag);
        int n, nb;
        n  = 1;
        nb = 0;
        while (!done && n < 20) begin
            nb += int'(busy);
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, W + 1);
        chk({tag, "_busy"}, nb, W);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        a     = x;
        b     = y;
        start = 1'b1;
        push(x, y);
        @(negedge clk);
        start = 1'b0;
        wait_done(tag);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            chk("busy_done", busy, 0);
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                logic [W+1:0] e;
                e = sb.pop_front();
                chk("sum", sum, e[W-1:0]);
                chk("cout", cout, e[W]);
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf", ovf, e[W+1]);
`endif
            end
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_sum", sum, 0);

        run_op(5'd10, 5'd7, "t2");
        run_op(5'd20, 5'd15, "t3a");
        run_op(5'd31, 5'd31, "t3b");
        repeat (2) @(negedge clk);

        a     = 5'd1;
        b     = 5'd2;
        start = 1'b1;
        push(5'd1, 5'd2);
        @(negedge clk);
        a = 5'd9;
        wait_done("t4a");
        push(5'd9, 5'd2);
        @(negedge clk);
        start = 1'b0;
        wait_done("t4b");
        repeat (2) @(negedge clk);

        a     = 5'd5;
        b     = 5'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        rst = 1'b0;
        repeat (W + 2) @(negedge clk);
        chk("abort_nodone", done, 0);
        run_op(5'd5, 5'd6, "t5");

        for (int i = 0; i < 200; i++) begin
            run_op(W'($urandom_range(0, 31)), W'($urandom_range(0, 31)), "rnd");
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
